uart_tx_frame: RTL

Parametrised UART transmitter, the next generation of the fixed 8N1 transmitter. It serialises one parallel word per valid/ready handshake into a standard asynchronous frame: start bit, LSB-first data, optional parity bit and one or two stop bits. Bit timing is paced by an external baud-rate `clock_enable` strobe, so the block sits between a baud tick generator and the board TX pin. Unlike its predecessor, it adds reset, configurable width, stop bits and parity, and true back-to-back streaming.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_frame.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state type, line levels and frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  localparam logic LineIdle  = 1'b1;
  localparam logic LineStart = 1'b0;
  localparam logic LineStop  = 1'b1;

  // Enabled ticks per frame: start + data + optional parity + stop bits.
  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input int unsigned parity,
                                            input int unsigned stop_bits);
    return 1 + data_bits + parity + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter paced by an external baud tick (clock_enable).
// Frame: start bit, LSB-first data, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 CLKIN,
  input  logic                 RESET,
  input  logic                 clock_enable,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx
);

  localparam int unsigned CntW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_BITS - 1);
  localparam logic [1:0] StopLast = 2'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 enter_stop;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Next-state logic: everything advances only on baud ticks.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    enter_stop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    if (clock_enable) begin
      unique case (state_q)
        StIdle: begin
          if (valid && ready_q) begin
            shreg_d = data;
            tx_d    = LineStart;
            ready_d = 1'b0;
            state_d = StStart;
`ifdef UART_TX_PARITY_EN
            // Parity taken from the word as accepted, before any shifting.
            par_d   = (^data) ^ PARITY_ODD[0];
`endif
          end
        end
        StStart: begin
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = '0;
          state_d = StData;
        end
        StData: begin
          if (cnt_q == CntLast) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = StParity;
`else
            enter_stop = 1'b1;
`endif
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          enter_stop = 1'b1;
        end
`endif
        StStop: begin
          // Only reached with two stop bits; the line is already high.
          if (stop_cnt_q == StopLast) begin
            state_d = StIdle;
            ready_d = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      // The first stop bit; ready rises on the edge that starts the last one.
      if (enter_stop) begin
        tx_d = LineStop;
        if (STOP_BITS == 1) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          state_d    = StStop;
          stop_cnt_d = 2'd1;
        end
      end
    end
  end

  // State registers with asynchronous reset to an idle, ready line.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      stop_cnt_q <= '0;
      tx_q       <= LineIdle;
      ready_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;

endmodule
